// File: rtl/cam_capture_pkg.sv
// Shared definitions for the camera capture front end: framebuffer geometry
// defaults, bus widths, the capture FSM state type and the pixel packing helper.
package cam_capture_pkg;

   localparam int AWIDTH_FBUFF = 19;
   localparam int DWIDTH_DAT   = 12;
   localparam int H_ACTIVE_DEF = 640;
   localparam int V_ACTIVE_DEF = 480;

   localparam int LINE_CNT_W = 9;

   typedef enum logic [1:0] {
      WAIT_VS = 2'd0,
      IN_VS   = 2'd1,
      CAPTURE = 2'd2
   } cap_state_t;

   // RGB444 pixel: low nibble of the first byte on top, whole second byte below
   function automatic logic [11:0] make_pixel(input logic [3:0] hi_nib, input logic [7:0] lo_byte);
      return {hi_nib, lo_byte};
   endfunction

endpackage

// File: rtl/cam_capture_sync.sv
// Three-flop synchronizer with edge detection for one asynchronous camera
// control line. Two flops resolve metastability, the third holds history so
// single-cycle rise/fall strobes can be derived in the system clock domain.
module cam_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic level,
   output logic rise,
   output logic fall
);

   logic s1;
   logic s2;
   logic s3;

   // Shift the raw line through the synchronizer and history flops
   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= d;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign level = s2;
   assign rise  = s2 & ~s3;
   assign fall  = ~s2 & s3;

endmodule

// File: rtl/cam_capture.sv
// Camera capture front end. Oversamples an OV-style parallel camera bus in the
// system clock domain, packs byte pairs into RGB444 pixels and issues one
// write strobe per stored pixel with a linear framebuffer address.
// Optional build macro CAM_CAPTURE_TEST_PATTERN_EN adds a test_pattern input
// that replaces camera data with a coordinate-derived pattern.
module cam_capture
   import cam_capture_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int AW       = AWIDTH_FBUFF,
   parameter int DW       = DWIDTH_DAT
) (
   input  logic                  sys_clk,
   input  logic                  rst,
   input  logic                  pclk,
   input  logic                  vsync_cam,
   input  logic                  href_cam,
   input  logic [7:0]            wdata_cam,
`ifdef CAM_CAPTURE_TEST_PATTERN_EN
   input  logic                  test_pattern,
`endif
   output logic [AW-1:0]         waddr,
   output logic [DW-1:0]         wdata,
   output logic                  wen,
   output logic                  frame_start,
   output logic                  frame_done,
   output logic [LINE_CNT_W-1:0] line_cnt
);

   localparam int XW = $clog2(H_ACTIVE + 1);
   localparam int YW = $clog2(V_ACTIVE + 1);

   localparam logic [XW-1:0] X_LIM     = XW'(H_ACTIVE);
   localparam logic [YW-1:0] Y_LIM     = YW'(V_ACTIVE);
   localparam logic [AW-1:0] LINE_STEP = AW'(H_ACTIVE);
   localparam logic [AW-1:0] LAST_ADDR = AW'(H_ACTIVE * V_ACTIVE - 1);

   logic pclk_rise;
   logic vs_rise;
   logic vs_fall;
   logic hr_level;
   logic hr_fall;
   logic unused_pclk_level;
   logic unused_pclk_fall;
   logic unused_vs_level;
   logic unused_hr_rise;

   logic [7:0] data_s1;
   logic [7:0] data_s2;

   cap_state_t state;
   cap_state_t state_next;
   logic       start_evt;

   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic [AW-1:0] addr;
   logic [AW-1:0] line_base;
   logic          phase;
   logic [3:0]    hi_nib;
   logic          armed;

   logic          pend_valid;
   logic [AW-1:0] pend_addr;
   logic [11:0]   pend_data;
   logic [11:0]   pixel;

   cam_sync u_sync_pclk (
      .clk   (sys_clk),
      .rst   (rst),
      .d     (pclk),
      .level (unused_pclk_level),
      .rise  (pclk_rise),
      .fall  (unused_pclk_fall)
   );

   cam_sync u_sync_vsync (
      .clk   (sys_clk),
      .rst   (rst),
      .d     (vsync_cam),
      .level (unused_vs_level),
      .rise  (vs_rise),
      .fall  (vs_fall)
   );

   cam_sync u_sync_href (
      .clk   (sys_clk),
      .rst   (rst),
      .d     (href_cam),
      .level (hr_level),
      .rise  (unused_hr_rise),
      .fall  (hr_fall)
   );

   // Camera byte follows the same two-flop depth as pclk so it is stable when pclk_rise fires
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         data_s1 <= '0;
         data_s2 <= '0;
      end else begin
         data_s1 <= wdata_cam;
         data_s2 <= data_s1;
      end
   end

`ifdef CAM_CAPTURE_TEST_PATTERN_EN
   logic [7:0] x_lo;
   logic [7:0] y_lo;

   assign x_lo  = 8'(x);
   assign y_lo  = 8'(y);
   assign pixel = test_pattern ? {x_lo[7:4], y_lo[7:4], x_lo[3:0]}
                               : make_pixel(hi_nib, data_s2);
`else
   assign pixel = make_pixel(hi_nib, data_s2);
`endif

   // Frame state register
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state <= WAIT_VS;
      end else begin
         state <= state_next;
      end
   end

   // Frame sequencing: a full vsync pulse must be seen before capturing, and a new pulse abandons the frame
   always_comb begin
      state_next = state;
      start_evt  = 1'b0;
      case (state)
         WAIT_VS: begin
            if (vs_rise) begin
               state_next = IN_VS;
            end
         end
         IN_VS: begin
            if (vs_fall) begin
               state_next = CAPTURE;
               start_evt  = 1'b1;
            end
         end
         CAPTURE: begin
            if (vs_rise) begin
               state_next = IN_VS;
            end
         end
         default: begin
            state_next = WAIT_VS;
         end
      endcase
   end

   // Byte pairing, line/column tracking and address generation; a line already active at frame start stays disarmed until its href falls
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         x          <= '0;
         y          <= '0;
         addr       <= '0;
         line_base  <= '0;
         phase      <= 1'b0;
         hi_nib     <= '0;
         armed      <= 1'b0;
         line_cnt   <= '0;
         pend_valid <= 1'b0;
         pend_addr  <= '0;
         pend_data  <= '0;
      end else begin
         pend_valid <= 1'b0;
         if (start_evt) begin
            x         <= '0;
            y         <= '0;
            addr      <= '0;
            line_base <= '0;
            phase     <= 1'b0;
            line_cnt  <= '0;
            armed     <= ~hr_level;
         end else if (state == CAPTURE) begin
            if (hr_fall) begin
               if (x != '0) begin
                  if (line_cnt != '1) begin
                     line_cnt <= line_cnt + LINE_CNT_W'(1);
                  end
                  if (y < Y_LIM) begin
                     y         <= y + YW'(1);
                     line_base <= line_base + LINE_STEP;
                     addr      <= line_base + LINE_STEP;
                  end else begin
                     addr <= line_base;
                  end
               end
               x     <= '0;
               phase <= 1'b0;
               armed <= 1'b1;
            end else if (pclk_rise && armed && hr_level) begin
               if (!phase) begin
                  hi_nib <= data_s2[3:0];
                  phase  <= 1'b1;
               end else begin
                  phase <= 1'b0;
                  if (x < X_LIM) begin
                     if (y < Y_LIM) begin
                        pend_valid <= 1'b1;
                        pend_addr  <= addr;
                        pend_data  <= pixel;
                     end
                     x    <= x + XW'(1);
                     addr <= addr + AW'(1);
                  end
               end
            end
         end
      end
   end

   // Output stage: one-cycle strobes, write data/address held until the next stored pixel
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         wen         <= 1'b0;
         waddr       <= '0;
         wdata       <= '0;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         wen         <= pend_valid;
         frame_start <= start_evt;
         frame_done  <= pend_valid && (pend_addr == LAST_ADDR);
         if (pend_valid) begin
            waddr <= pend_addr;
            wdata <= DW'(pend_data);
         end
      end
   end

endmodule

// File: tb/tb_cam_capture.sv
// Directed testbench for cam_capture: byte-pair table on a short line, then
// multi-line frame sequences for clipping, short lines, frame end and reset.
module tb_cam_capture;

   localparam int H  = 640;
   localparam int V  = 3;
   localparam int AW = 19;
   localparam int DW = 12;

   logic          sys_clk = 1'b0;
   logic          rst;
   logic          pclk;
   logic          vsync_cam;
   logic          href_cam;
   logic [7:0]    wdata_cam;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;
   logic          wen;
   logic          frame_start;
   logic          frame_done;
   logic [8:0]    line_cnt;
`ifdef CAM_CAPTURE_TEST_PATTERN_EN
   logic          test_pattern = 1'b0;
`endif

   typedef struct {
      int addr;
      int data;
   } wr_t;

   typedef struct {
      logic [7:0] hi;
      logic [7:0] lo;
      int         exp_addr;
      int         exp_data;
   } vec_t;

   wr_t  wr_q[$];
   vec_t vecs[6];
   bit   written_map[H*V];

   int n_checks = 0;
   int n_fail   = 0;
   int wen_cnt  = 0;
   int fs_cnt   = 0;
   int fd_cnt   = 0;
   int fd_addr  = -1;
   int fd_with_wen = 0;
   int pulse_viol  = 0;
   logic prev_wen = 1'b0;
   logic prev_fs  = 1'b0;
   logic prev_fd  = 1'b0;

   always #5 sys_clk = ~sys_clk;

   cam_capture #(
      .H_ACTIVE (H),
      .V_ACTIVE (V)
   ) dut (
      .sys_clk     (sys_clk),
      .rst         (rst),
      .pclk        (pclk),
      .vsync_cam   (vsync_cam),
      .href_cam    (href_cam),
      .wdata_cam   (wdata_cam),
`ifdef CAM_CAPTURE_TEST_PATTERN_EN
      .test_pattern(test_pattern),
`endif
      .waddr       (waddr),
      .wdata       (wdata),
      .wen         (wen),
      .frame_start (frame_start),
      .frame_done  (frame_done),
      .line_cnt    (line_cnt)
   );

   // Record every write and pulse shortly after each rising edge
   always @(posedge sys_clk) begin
      #1;
      if (wen) begin
         wr_q.push_back('{addr: int'(waddr), data: int'(wdata)});
         wen_cnt++;
         if (int'(waddr) < H*V) written_map[waddr] = 1'b1;
      end
      if (frame_start) fs_cnt++;
      if (frame_done) begin
         fd_cnt++;
         fd_addr     = int'(waddr);
         fd_with_wen = int'(wen);
      end
      if ((wen && prev_wen) || (frame_start && prev_fs) || (frame_done && prev_fd)) pulse_viol++;
      prev_wen = wen;
      prev_fs  = frame_start;
      prev_fd  = frame_done;
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      pclk      = 1'b0;
      wdata_cam = b;
      wait_cycles(2);
      pclk = 1'b1;
      wait_cycles(2);
   endtask

   task automatic send_pixel(input logic [7:0] hi, input logic [7:0] lo);
      send_byte(hi);
      send_byte(lo);
   endtask

   task automatic vsync_pulse();
      vsync_cam = 1'b1;
      wait_cycles(4);
      vsync_cam = 1'b0;
      wait_cycles(8);
   endtask

   // One line of n_pix pixels; pixel i carries value i, first byte's upper nibble is junk
   task automatic applyStimulus(input int n_pix, input logic [3:0] junk);
      logic [11:0] v;
      href_cam = 1'b1;
      wait_cycles(2);
      for (int i = 0; i < n_pix; i++) begin
         v = 12'(i);
         send_pixel({junk, v[11:8]}, v[7:0]);
      end
      href_cam = 1'b0;
      wait_cycles(12);
   endtask

   initial begin
      int holes;
      int stored;

      vecs[0] = '{hi: 8'h00, lo: 8'h00, exp_addr: 0, exp_data: 12'h000};
      vecs[1] = '{hi: 8'h0A, lo: 8'hBC, exp_addr: 1, exp_data: 12'hABC};
      vecs[2] = '{hi: 8'hFF, lo: 8'h12, exp_addr: 2, exp_data: 12'hF12};
      vecs[3] = '{hi: 8'h35, lo: 8'h00, exp_addr: 3, exp_data: 12'h500};
      vecs[4] = '{hi: 8'h70, lo: 8'hFF, exp_addr: 4, exp_data: 12'h0FF};
      vecs[5] = '{hi: 8'h9C, lo: 8'h5A, exp_addr: 5, exp_data: 12'hC5A};

      rst       = 1'b1;
      pclk      = 1'b0;
      vsync_cam = 1'b0;
      href_cam  = 1'b0;
      wdata_cam = 8'h00;
      wait_cycles(4);
      checkOutput("reset_wen", int'(wen), 0);
      checkOutput("reset_frame_start", int'(frame_start), 0);
      checkOutput("reset_frame_done", int'(frame_done), 0);
      checkOutput("reset_waddr", int'(waddr), 0);
      checkOutput("reset_wdata", int'(wdata), 0);
      checkOutput("reset_line_cnt", int'(line_cnt), 0);
      rst = 1'b0;
      wait_cycles(2);

      $display("[TB] bytes before any vsync");
      applyStimulus(4, 4'h0);
      checkOutput("prevs_wen_count", wen_cnt, 0);
      checkOutput("prevs_frame_start", fs_cnt, 0);

      $display("[TB] first frame, table-driven pixels");
      vsync_pulse();
      checkOutput("first_frame_start", fs_cnt, 1);
      wr_q.delete();
      href_cam = 1'b1;
      wait_cycles(2);
      for (int i = 0; i < 6; i++) begin
         send_pixel(vecs[i].hi, vecs[i].lo);
         wait_cycles(6);
         checkOutput($sformatf("vec%0d_wen_count", i), wr_q.size(), 1);
         if (wr_q.size() > 0) begin
            checkOutput($sformatf("vec%0d_waddr", i), wr_q[0].addr, vecs[i].exp_addr);
            checkOutput($sformatf("vec%0d_wdata", i), wr_q[0].data, vecs[i].exp_data);
            void'(wr_q.pop_front());
         end
      end
      href_cam = 1'b0;
      wait_cycles(12);
      checkOutput("table_line_cnt", int'(line_cnt), 1);
      checkOutput("table_no_frame_done", fd_cnt, 0);

      $display("[TB] clipped, short and full lines");
      vsync_pulse();
      checkOutput("frame2_start", fs_cnt, 2);
      checkOutput("frame2_line_cnt_clear", int'(line_cnt), 0);
      foreach (written_map[k]) written_map[k] = 1'b0;

      wr_q.delete();
      applyStimulus(645, 4'h1);
      checkOutput("long_line_wen_count", wr_q.size(), 640);
      if (wr_q.size() == 640) begin
         checkOutput("long_line_first_addr", wr_q[0].addr, 0);
         checkOutput("long_line_last_addr", wr_q[639].addr, 639);
         checkOutput("long_line_last_data", wr_q[639].data, 639);
         checkOutput("long_line_mid_data", wr_q[300].data, 300);
      end
      checkOutput("long_line_line_cnt", int'(line_cnt), 1);

      wr_q.delete();
      applyStimulus(100, 4'h2);
      checkOutput("short_line_wen_count", wr_q.size(), 100);
      if (wr_q.size() == 100) begin
         checkOutput("short_line_first_addr", wr_q[0].addr, 640);
         checkOutput("short_line_last_addr", wr_q[99].addr, 739);
      end
      checkOutput("short_line_line_cnt", int'(line_cnt), 2);

      wr_q.delete();
      applyStimulus(640, 4'h3);
      checkOutput("last_line_wen_count", wr_q.size(), 640);
      if (wr_q.size() == 640) begin
         checkOutput("last_line_first_addr", wr_q[0].addr, 1280);
         checkOutput("last_line_last_addr", wr_q[639].addr, 1919);
         checkOutput("last_line_last_data", wr_q[639].data, 639);
      end
      checkOutput("frame_done_count", fd_cnt, 1);
      checkOutput("frame_done_addr", fd_addr, 1919);
      checkOutput("frame_done_with_wen", fd_with_wen, 1);
      checkOutput("last_line_line_cnt", int'(line_cnt), 3);

      wr_q.delete();
      applyStimulus(10, 4'h4);
      checkOutput("extra_line_wen_count", wr_q.size(), 0);
      checkOutput("extra_line_line_cnt", int'(line_cnt), 4);
      checkOutput("extra_line_frame_done", fd_cnt, 1);

      holes  = 0;
      stored = 0;
      for (int a = 0; a < H*V; a++) begin
         if (written_map[a]) stored++;
         if (a >= 740 && a < 1280 && written_map[a]) holes++;
      end
      checkOutput("short_line_holes", holes, 0);
      checkOutput("frame_stored_pixels", stored, 1380);

      $display("[TB] reset mid-line");
      vsync_pulse();
      checkOutput("frame3_start", fs_cnt, 3);
      wr_q.delete();
      href_cam = 1'b1;
      wait_cycles(2);
      send_byte(8'h05);
      rst = 1'b1;
      @(negedge sys_clk);
      checkOutput("midline_reset_wen", int'(wen), 0);
      checkOutput("midline_reset_waddr", int'(waddr), 0);
      checkOutput("midline_reset_wdata", int'(wdata), 0);
      checkOutput("midline_reset_line_cnt", int'(line_cnt), 0);
      checkOutput("midline_reset_frame_done", int'(frame_done), 0);
      rst = 1'b0;
      send_byte(8'hAB);
      send_pixel(8'h01, 8'h23);
      send_pixel(8'h04, 8'h56);
      href_cam = 1'b0;
      wait_cycles(12);
      checkOutput("post_reset_no_wen", wr_q.size(), 0);
      checkOutput("post_reset_no_start", fs_cnt, 3);

      vsync_pulse();
      checkOutput("recovery_frame_start", fs_cnt, 4);
      href_cam = 1'b1;
      wait_cycles(2);
      send_pixel(8'h0A, 8'hBC);
      href_cam = 1'b0;
      wait_cycles(12);
      checkOutput("recovery_wen_count", wr_q.size(), 1);
      if (wr_q.size() == 1) begin
         checkOutput("recovery_waddr", wr_q[0].addr, 0);
         checkOutput("recovery_wdata", wr_q[0].data, 12'hABC);
      end

      checkOutput("pulse_rule_violations", pulse_viol, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cam_capture.md
Name: cam_capture

Overview:
- Camera front end feeding `mem_controller`'s framebuffer write port.
- Takes the raw OV-style parallel bus (pclk, vsync, href, 8-bit data) and oversamples it entirely in the `sys_clk` domain.
- Assembles each byte pair into one 12-bit RGB444 pixel.
- Emits one single-cycle write strobe per pixel with a linear framebuffer address, plus frame/line status.

Parameters:
- H_ACTIVE, 640, pixels per line stored.
- V_ACTIVE, 480, lines per frame stored.
- AW, `awidth_fbuff (19), framebuffer address width.
- DW, `dwidth_dat (12), pixel width.

Ports:
- sys_clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- pclk  in  1  raw camera pixel clock, asynchronous, ≤ sys_clk/4.
- vsync_cam  in  1  raw frame sync, high between frames.
- href_cam  in  1  raw line valid.
- wdata_cam  in  8  raw camera byte.
- waddr  out  AW  framebuffer write address.
- wdata  out  DW  pixel {hi[3:0], lo[7:0]}.
- wen  out  1  one-cycle write strobe.
- frame_start  out  1  one-cycle pulse on vsync falling edge.
- frame_done  out  1  one-cycle pulse when pixel V_ACTIVE*H_ACTIVE-1 is written.
- line_cnt  out  9  lines completed in current frame.

Behaviour:
- Synchronisation
  - pclk, vsync_cam and href_cam each pass through 2 flops plus 1 history flop.
  - wdata_cam passes through 2 flops, aligned with the pclk synchronizer.
  - pclk_rise = s2 & ~s3; similarly vs_rise/vs_fall and hr_fall.
  - Data is sampled only in a pclk_rise cycle.
- FSM states: WAIT_VS, IN_VS, CAPTURE.
  - Reset → WAIT_VS. No writes occur until a full vsync pulse has been seen after reset.
  - WAIT_VS: vs_rise → IN_VS.
  - IN_VS: vs_fall → CAPTURE. On this transition: pulse frame_start, clear x, y, addr, phase, line_cnt.
  - CAPTURE: vs_rise → IN_VS. An incomplete frame is abandoned with no frame_done.
- Byte assembly (CAPTURE, href synced high, pclk_rise)
  - phase 0: latch byte[3:0] as hi; byte[7:4] ignored; phase ← 1.
  - phase 1: form the pixel. If x < H_ACTIVE and y < V_ACTIVE, register wdata and waddr=addr, and assert wen the next sys_clk cycle. Then x++, addr++, phase ← 0.
- Line handling
  - Extra pixels with x ≥ H_ACTIVE are dropped without incrementing addr.
  - hr_fall: if x > 0, then y++, line_cnt++, and addr ← y_next*H_ACTIVE (held as a running line-base register, no multiplier). Always x ← 0, phase ← 0.
  - A short line (x < H_ACTIVE) leaves unwritten holes; the next line still starts at its line base.
  - href high at vs_fall is ignored until its first falling edge.
  - Lines with y ≥ V_ACTIVE are dropped.
- frame_done: pulses in the same cycle as the wen for address H_ACTIVE*V_ACTIVE-1.
- Latency: wen asserts 3 sys_clk edges after the first sys_clk edge that samples the second byte's raw pclk rise.
- Pulse rules: wen, frame_start and frame_done are single-cycle and never asserted two cycles in a row.
- Reset (any time, including mid-line): all outputs 0, FSM WAIT_VS, synchronizer flops cleared.

Optional Feature:
- Macro CAM_CAPTURE_TEST_PATTERN_EN.
- When defined:
  - Adds input port test_pattern (1 bit, sampled each cycle).
  - When test_pattern=1, wdata = {x[7:4], y[7:4], x[3:0]} instead of camera data.
  - Timing, addressing and strobes are unchanged, so the ALU/VGA path can be checked without a sensor.
- When undefined: no port and no logic; wdata always comes from camera bytes.

Decomposition:
- Shared defines header (existing): `awidth_fbuff`, `dwidth_dat`, plus new `H_ACTIVE_DEF=640` and `V_ACTIVE_DEF=480`.
- FSM state encodings are local parameters.
- One sub-module, `cam_sync`: 3-flop synchronizer/edge detector, instanced for pclk, vsync and href. Outputs are level, rise and fall.

Test Plan:
- Reset then vsync pulse 40 ns, then bytes 0x00,0x00 / 0x0A,0xBC at pclk 25 MHz with href high → frame_start once; wen twice; waddr 0 then 1; wdata 0x000 then 0xABC.
- Bytes sent before any vsync after reset → no wen, FSM stays WAIT_VS.
- Line of 645 pixels followed by href fall → exactly 640 wen; next line's first waddr = 640; line_cnt = 1.
- Short line of 100 pixels then full line → second line starts at waddr 640; addresses 100–639 never written.
- Full 640x480 frame with a 481st line → last wen at waddr 307199 coincident with frame_done; 481st line produces no wen.
- rst asserted mid-line after the hi byte → all outputs 0 next cycle; subsequent bytes ignored until a new vsync pulse.
